// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential restoring divider (16-bit dividend / 8-bit divisor).
// Produces one quotient bit per clock, MSB first, behind a valid/ready
// handshake on both sides with a single division in flight.
module div_16x8_seq #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  q_ovf,
   output logic                  div_zero
);

   localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state_reg;
   logic [CNT_W-1:0]      cnt_reg;
   // Dividend bits shift out at the top while quotient bits shift in at the
   // bottom; after the last step this register holds the full quotient.
   logic [DIVIDEND_W-1:0] work_reg;
   logic [DIVISOR_W-1:0]  divisor_reg;
   // Partial remainder is always below the divisor after a step, so only
   // DIVISOR_W bits need to be stored; the extra bit exists only in pr_shift.
   logic [DIVISOR_W-1:0]  pr_reg;

   logic [DIVIDEND_W-1:0] quotient_reg;
   logic [DIVISOR_W-1:0]  remainder_reg;
   logic                  q_ovf_reg;
   logic                  div_zero_reg;

   logic [DIVISOR_W:0]    pr_shift;
   logic [DIVISOR_W:0]    pr_diff;
   logic                  step_ge;
   logic [DIVISOR_W-1:0]  pr_next;
   logic [DIVIDEND_W-1:0] work_next;

   // One restoring step: shift in next dividend bit, trial-subtract, restore.
   always_comb begin
      pr_shift  = {pr_reg, work_reg[DIVIDEND_W-1]};
      pr_diff   = pr_shift - {1'b0, divisor_reg};
      // If the shifted value reached the top bit it is certainly >= divisor;
      // otherwise a borrow into the top bit of the difference means "less".
      step_ge   = pr_shift[DIVISOR_W] | ~pr_diff[DIVISOR_W];
      pr_next   = step_ge ? pr_diff[DIVISOR_W-1:0] : pr_shift[DIVISOR_W-1:0];
      work_next = {work_reg[DIVIDEND_W-2:0], step_ge};
   end

   // Control FSM, datapath iteration and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         work_reg      <= '0;
         divisor_reg   <= '0;
         pr_reg        <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         q_ovf_reg     <= 1'b0;
         div_zero_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  work_reg    <= dividend;
                  divisor_reg <= divisor;
                  cnt_reg     <= '0;
                  pr_reg      <= '0;
                  if (divisor == '0) begin
                     // Division by zero resolves immediately with saturated flags.
                     quotient_reg  <= '1;
                     remainder_reg <= dividend[DIVISOR_W-1:0];
                     q_ovf_reg     <= 1'b1;
                     div_zero_reg  <= 1'b1;
                     state_reg     <= ST_DONE;
                  end else begin
                     state_reg <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               work_reg <= work_next;
               pr_reg   <= pr_next;
               cnt_reg  <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(DIVIDEND_W - 1)) begin
                  quotient_reg  <= work_next;
                  remainder_reg <= pr_next;
                  q_ovf_reg     <= |work_next[DIVIDEND_W-1:DIVISOR_W];
                  div_zero_reg  <= 1'b0;
                  state_reg     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign quotient  = quotient_reg;
   assign remainder = remainder_reg;
   assign q_ovf     = q_ovf_reg;
   assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div_16x8_seq.sv
// tb_div_16x8_seq: directed scoreboard bench for the sequential divider.
module tb_div_16x8_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        q_ovf;
   logic        div_zero;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        ovf;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   div_16x8_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .q_ovf(q_ovf), .div_zero(div_zero)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   function automatic exp_t model(input int unsigned d, input int unsigned b);
      exp_t e;
      int unsigned qq;
      if (b == 0) begin
         e.q = 16'hFFFF; e.r = 8'(d & 32'hFF); e.ovf = 1'b1; e.dz = 1'b1;
      end else begin
         qq = d / b;
         e.q = 16'(qq); e.r = 8'(d % b); e.ovf = (qq > 255); e.dz = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_quotient"},  32'(quotient),  32'd0);
      chk({tag, "_remainder"}, 32'(remainder), 32'd0);
      chk({tag, "_q_ovf"},     32'(q_ovf),     32'd0);
      chk({tag, "_div_zero"},  32'(div_zero),  32'd0);
   endtask

   // Present one request; returns #1 after the accept edge.
   task automatic drive_op(input logic [15:0] d, input logic [7:0] b);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      dividend = d;
      divisor  = b;
      in_valid = 1'b1;
      sb.push_back(model(d, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
   endtask

   // Count edges until out_valid, then pop the scoreboard and compare.
   task automatic wait_result(input int exp_lat, input string tag);
      int   cyc  = 0;
      bit   seen = 0;
      exp_t e;
      while (!seen && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (out_valid) seen = 1;
         else chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_quotient"},  32'(quotient),  32'(e.q));
         chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
         chk({tag, "_q_ovf"},     32'(q_ovf),     32'(e.ovf));
         chk({tag, "_div_zero"},  32'(div_zero),  32'(e.dz));
         chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
         $display("op %s: q=%0d r=%0d ovf=%0b dz=%0b latency=%0d", tag,
                  quotient, remainder, q_ovf, div_zero, cyc);
      end
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_exit_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_exit_in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      int seen_out;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      // Exact product recovery plus a constant cross-check
      drive_op(16'd35055, 8'd205);
      wait_result(16, "exact_35055_205");
      chk("exact_q_const", 32'(quotient), 32'd171);
      release_result("exact");

      drive_op(16'd40001, 8'd200); wait_result(16, "40001_200"); release_result("r1");
      drive_op(16'd7,     8'd9);   wait_result(16, "7_9");       release_result("r2");
      drive_op(16'd0,     8'd1);   wait_result(16, "0_1");       release_result("r3");
      drive_op(16'd65535, 8'd255); wait_result(16, "65535_255"); release_result("r4");
      drive_op(16'd65535, 8'd1);   wait_result(16, "65535_1");   release_result("r5");

      // Divide by zero resolves in one cycle
      drive_op(16'd100, 8'd0);
      wait_result(1, "100_0");
      release_result("dz");

      // out_ready already high on DONE entry: exactly one cycle in DONE
      out_ready = 1'b1;
      drive_op(16'd1234, 8'd7);
      wait_result(16, "1234_7_rdy");
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rdy_high_exit_out_valid", 32'(out_valid), 32'd0);
      chk("rdy_high_exit_in_ready",  32'(in_ready),  32'd1);

      // Backpressure: hold result for 10 cycles, with noise on the input side
      drive_op(16'd50000, 8'd3);
      wait_result(16, "50000_3");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'($urandom);
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_quotient",  32'(quotient),  32'd16666);
         chk("bp_remainder", 32'(remainder), 32'd2);
      end
      // Request held across the DONE-exit edge must not be taken on that edge
      in_valid = 1'b1; dividend = 16'd35055; divisor = 8'd205; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_exit_in_ready",  32'(in_ready),  32'd1);
      chk("bp_exit_out_valid", 32'(out_valid), 32'd0);
      sb.push_back(model(35055, 205));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_result(16, "after_bp_35055_205");
      release_result("after_bp");

      // Reset while in CALC: the reset edge is the 8th step edge
      drive_op(16'd40001, 8'd200);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      check_reset_state("midop_reset");
      seen_out = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen_out++;
      end
      chk("midop_no_output", 32'(seen_out), 32'd0);
      drive_op(16'd35055, 8'd205);
      wait_result(16, "post_reset_35055_205");
      chk("post_reset_q_const", 32'(quotient), 32'd171);
      release_result("post_reset");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
